fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter NUM_TAPS, default 4: number of coefficient registers written per load.
REQ-002 Parameter COEFF_BASE, default 32'h0000_000C: address of coefficient 0; coefficient k is at COEFF_BASE + 4*k.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles allowed for any single handshake wait.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle load request, honoured only when idle.
REQ-007 preset  in  2  coefficient source: 0 lowpass, 1 highpass, 2 passthrough, 3 user.
REQ-008 user_coeffs  in  16*NUM_TAPS  Q1.15 user coefficients; coefficient k is at bits [16k+15:16k].
REQ-009 axi_awaddr/axi_awprot/axi_awvalid  out  32/3/1; axi_awready  in  1: AXI4-Lite master write address channel.
REQ-010 axi_wdata/axi_wstrb/axi_wvalid  out  32/4/1; axi_wready  in  1: write data channel.
REQ-011 axi_bresp  in  2; axi_bvalid  in  1; axi_bready  out  1: write response channel.
REQ-012 axi_araddr/axi_arprot/axi_arvalid  out  32/3/1; axi_arready  in  1: read address channel.
REQ-013 axi_rdata  in  32; axi_rresp  in  2; axi_rvalid  in  1; axi_rready  out  1: read data channel.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle pulse at the end of a load, whether it succeeded or failed.
REQ-016 err_code  out  2  0 ok, 1 bad write response, 2 readback fault, 3 timeout; sticky until the next accepted start.
REQ-017 err_index  out  $clog2(NUM_TAPS) (minimum 1)  tap index of the first error.

Function
REQ-018 Presets with NUM_TAPS=4 shall be: lowpass 2000,2000,2000,2000; highpass 2000,E000,E000,2000; passthrough 7FFF,0000,0000,0000; user = user_coeffs.
REQ-019 For NUM_TAPS > 4, taps 4 and up shall be 0000 in every preset except user.
REQ-020 On an accepted start, preset and user_coeffs shall be latched; later changes to them shall have no effect on the load in progress.
REQ-021 FSM states shall be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, FINISH.
REQ-022 IDLE to WR_REQ on start; start while busy shall be ignored.
REQ-023 In WR_REQ, axi_awvalid and axi_wvalid shall both be driven high in the cycle after entry.
REQ-024 In WR_REQ, each of axi_awvalid and axi_wvalid shall drop independently on its own handshake; the FSM shall go to WR_RESP once both handshakes are complete, including when they occur in the same cycle.
REQ-025 Write data shall be {16'h0000, coeff}, with axi_wstrb=4'hF and axi_awprot=axi_arprot=3'b000.
REQ-026 axi_bready shall be high only in WR_RESP.
REQ-027 On a B handshake with bresp=OKAY, advance to the next tap, or leave the write phase after tap NUM_TAPS-1.
REQ-028 On a B handshake with bresp other than OKAY, set err_code=1 and err_index=tap, then go to FINISH.
REQ-029 Valid signals shall be held stable until their handshake completes, per AXI rules.
REQ-030 A watchdog counter shall be cleared on each state entry and on each handshake.
REQ-031 If the watchdog reaches TIMEOUT, set err_code=3 and err_index=tap, deassert all valid and ready outputs, and go to FINISH.
REQ-032 FINISH shall last exactly one cycle: done=1 and busy=0 in that cycle, then return to IDLE.
REQ-033 Minimum load latency with zero-wait slaves: 3 cycles per tap for writes, plus 1 FINISH cycle.

Reset
REQ-034 Asserting rst_n low shall immediately force IDLE and clear all state.
REQ-035 During reset, every valid and ready output, busy, done, err_code, err_index, and the tap counter shall be 0.
REQ-036 During reset, address and data outputs shall be 0.
REQ-037 A reset in the middle of a transfer shall abandon that transfer without generating a done pulse.

Configuration
REQ-038 Macro FIR_COEFF_READBACK_EN, when defined, shall add a read phase: after the last write, go through RD_REQ (axi_arvalid high until its handshake) and RD_DATA (axi_rready high) for each tap.
REQ-039 In the read phase, rresp other than OKAY, or rdata[15:0] not equal to the written coefficient, shall set err_code=2 and err_index=tap, then go to FINISH.
REQ-040 Without FIR_COEFF_READBACK_EN, the RD states shall be unreachable, axi_arvalid and axi_rready shall be tied to 0, and the FSM shall go from the last write straight to FINISH.

Verification
REQ-041 Highpass load with a zero-wait slave: start with preset=1 -> writes 0x0C=2000, 0x10=E000, 0x14=E000, 0x18=2000 in order; done after 13 cycles; err_code=0.
REQ-042 Write handshake ordering: slave asserts wready 3 cycles before awready -> wvalid drops first, awvalid held; exactly one write per tap.
REQ-043 Write error: slave returns bresp=2'b10 on tap 2 -> err_code=1, err_index=2, no tap-3 write, done pulse.
REQ-044 Timeout: awready stuck at 0 -> done at the TIMEOUT bound, err_code=3, awvalid deasserted.
REQ-045 Readback (macro on): slave corrupts the tap-1 readback to 2001 -> err_code=2, err_index=1. Abort: start, reset after 5 cycles -> all outputs 0, no done.
REQ-046 start during busy is ignored; a second start after done clears err_code.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: AXI4-Lite master writing FIR coefficient presets.
// Define FIR_COEFF_READBACK_EN to add a readback verify pass.
module fir_coeff_loader #(
    parameter int          NUM_TAPS   = 4,
    parameter logic [31:0] COEFF_BASE = 32'h0000_000C,
    parameter int          TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               preset,
    input  logic [16*NUM_TAPS-1:0]   user_coeffs,
    output logic [31:0]              axi_awaddr,
    output logic [2:0]               axi_awprot,
    output logic                     axi_awvalid,
    input  logic                     axi_awready,
    output logic [31:0]              axi_wdata,
    output logic [3:0]               axi_wstrb,
    output logic                     axi_wvalid,
    input  logic                     axi_wready,
    input  logic [1:0]               axi_bresp,
    input  logic                     axi_bvalid,
    output logic                     axi_bready,
    output logic [31:0]              axi_araddr,
    output logic [2:0]               axi_arprot,
    output logic                     axi_arvalid,
    input  logic                     axi_arready,
    input  logic [31:0]              axi_rdata,
    input  logic [1:0]               axi_rresp,
    input  logic                     axi_rvalid,
    output logic                     axi_rready,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err_code,
    output logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0] err_index
);

    localparam int IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] E_OK   = 2'd0;
    localparam logic [1:0] E_BRSP = 2'd1;
    localparam logic [1:0] E_RDBK = 2'd2;
    localparam logic [1:0] E_TMO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        FINISH
    } state_t;

    state_t         state;
    logic [IW-1:0]  tap;
    logic [WW-1:0]  wdog;
    logic           issued;
    logic           aw_ok;
    logic           w_ok;
    logic [15:0]    coeff_q [NUM_TAPS];

    logic           aw_hs;
    logic           w_hs;
    logic           b_hs;
    logic           ar_hs;
    logic           r_hs;
    logic           any_hs;
    logic           in_wait;
    logic           wd_fire;
    logic           last_tap;
    logic [31:0]    tap_addr;
    logic [15:0]    cur_coeff;

    assign axi_awprot = 3'b000;
    assign axi_arprot = 3'b000;
    assign axi_wstrb  = 4'hF;

    assign aw_hs     = axi_awvalid & axi_awready;
    assign w_hs      = axi_wvalid & axi_wready;
    assign b_hs      = axi_bvalid & axi_bready;
    assign last_tap  = (tap == IW'(NUM_TAPS - 1));
    assign tap_addr  = COEFF_BASE + (32'(tap) << 2);
    assign cur_coeff = coeff_q[tap];

    assign in_wait = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);
    assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign wd_fire = in_wait && !any_hs && (wdog == WW'(TIMEOUT - 1));

`ifdef FIR_COEFF_READBACK_EN
    logic        ar_valid_q;
    logic        r_ready_q;
    logic [31:0] ar_addr_q;
    logic        unused_rd;

    assign axi_arvalid = ar_valid_q;
    assign axi_rready  = r_ready_q;
    assign axi_araddr  = ar_addr_q;
    assign ar_hs       = ar_valid_q & axi_arready;
    assign r_hs        = r_ready_q & axi_rvalid;
    assign unused_rd   = ^axi_rdata[31:16];
`else
    logic unused_rd;

    assign axi_arvalid = 1'b0;
    assign axi_rready  = 1'b0;
    assign axi_araddr  = 32'h0;
    assign ar_hs       = 1'b0;
    assign r_hs        = 1'b0;
    assign unused_rd   = ^{axi_arready, axi_rdata, axi_rresp, axi_rvalid};
`endif

    // Coefficient of tap k for a preset; upper taps are zero except for user.
    function automatic logic [15:0] preset_coeff(
        input logic [1:0]              p,
        input logic [16*NUM_TAPS-1:0]  u,
        input int                      k
    );
        logic [15:0] c;
        c = 16'h0000;
        unique case (p)
            2'd0: c = (k < 4) ? 16'h2000 : 16'h0000;
            2'd1: begin
                if (k == 0 || k == 3)
                    c = 16'h2000;
                else if (k < 4)
                    c = 16'hE000;
            end
            2'd2: c = (k == 0) ? 16'h7FFF : 16'h0000;
            default: c = u[16*k +: 16];
        endcase
        return c;
    endfunction

    // Watchdog: restarts on every handshake and whenever outside a wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wdog <= '0;
        else if (!in_wait || any_hs)
            wdog <= '0;
        else if (!wd_fire)
            wdog <= wdog + 1'b1;
        else
            wdog <= '0;
    end

    // Load sequencer: latch coefficients, write each tap, optionally verify.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tap         <= '0;
            issued      <= 1'b0;
            aw_ok       <= 1'b0;
            w_ok        <= 1'b0;
            axi_awaddr  <= 32'h0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= 32'h0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_code    <= E_OK;
            err_index   <= '0;
            for (int k = 0; k < NUM_TAPS; k++)
                coeff_q[k] <= 16'h0000;
`ifdef FIR_COEFF_READBACK_EN
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            ar_addr_q   <= 32'h0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_TAPS; k++)
                            coeff_q[k] <= preset_coeff(preset, user_coeffs, k);
                        tap       <= '0;
                        issued    <= 1'b0;
                        aw_ok     <= 1'b0;
                        w_ok      <= 1'b0;
                        err_code  <= E_OK;
                        err_index <= '0;
                        busy      <= 1'b1;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (!issued) begin
                        issued      <= 1'b1;
                        axi_awaddr  <= tap_addr;
                        axi_wdata   <= {16'h0000, cur_coeff};
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                    end else if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                        axi_awvalid <= 1'b0;
                        axi_wvalid  <= 1'b0;
                        aw_ok       <= 1'b0;
                        w_ok        <= 1'b0;
                        axi_bready  <= 1'b1;
                        state       <= WR_RESP;
                    end else begin
                        if (aw_hs) begin
                            axi_awvalid <= 1'b0;
                            aw_ok       <= 1'b1;
                        end
                        if (w_hs) begin
                            axi_wvalid <= 1'b0;
                            w_ok       <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        axi_bready <= 1'b0;
                        issued     <= 1'b0;
                        if (axi_bresp != 2'b00) begin
                            err_code  <= E_BRSP;
                            err_index <= tap;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= FINISH;
                        end else if (last_tap) begin
`ifdef FIR_COEFF_READBACK_EN
                            tap   <= '0;
                            state <= RD_REQ;
`else
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
`endif
                        end else begin
                            tap   <= tap + 1'b1;
                            state <= WR_REQ;
                        end
                    end
                end
`ifdef FIR_COEFF_READBACK_EN
                RD_REQ: begin
                    if (!issued) begin
                        issued     <= 1'b1;
                        ar_addr_q  <= tap_addr;
                        ar_valid_q <= 1'b1;
                    end else if (ar_hs) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        r_ready_q <= 1'b0;
                        issued    <= 1'b0;
                        if (axi_rresp != 2'b00 ||
                            axi_rdata[15:0] != cur_coeff) begin
                            err_code  <= E_RDBK;
                            err_index <= tap;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= FINISH;
                        end else if (last_tap) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end else begin
                            tap   <= tap + 1'b1;
                            state <= RD_REQ;
                        end
                    end
                end
`endif
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A stalled handshake overrides everything and ends the load.
            if (wd_fire) begin
                err_code    <= E_TMO;
                err_index   <= tap;
                axi_awvalid <= 1'b0;
                axi_wvalid  <= 1'b0;
                axi_bready  <= 1'b0;
                done        <= 1'b1;
                busy        <= 1'b0;
                state       <= FINISH;
`ifdef FIR_COEFF_READBACK_EN
                ar_valid_q  <= 1'b0;
                r_ready_q   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: randomized AXI slave plus behavioural load model.
// Readback scenarios compile in when FIR_COEFF_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_fir_coeff_loader;

    localparam int          N    = 4;
    localparam int          T    = 64;
    localparam logic [31:0] BASE = 32'h0000_000C;
`ifdef FIR_COEFF_READBACK_EN
    localparam int          RB   = 1;
`else
    localparam int          RB   = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  preset = 2'd0;
    logic [63:0] user_coeffs = 64'h0;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [1:0]  err_index;

    fir_coeff_loader #(.NUM_TAPS(N), .COEFF_BASE(BASE), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .preset(preset),
        .user_coeffs(user_coeffs),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .busy(busy), .done(done), .err_code(err_code), .err_index(err_index)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Preset tables as written in the coefficient plan.
    logic [15:0] tbl [3][4] = '{
        '{16'h2000, 16'h2000, 16'h2000, 16'h2000},
        '{16'h2000, 16'hE000, 16'hE000, 16'h2000},
        '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000}
    };

    // Slave configuration and log.
    int          aw_lat = 0, w_lat = 0, b_lat = 0;
    int          bad_tap = -1, bad_rd_tap = -1;
    bit          stuck_aw = 1'b0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] mem [N];

    // Monitor/model state.
    int          cyc = 0;
    bit          in_load = 1'b0;
    int          aw_n = 0, w_n = 0;
    int          start_cycle = 0, done_cycle = 0, done_count = 0;
    bit          saw_split = 1'b0;
    logic [15:0] exp_coeff [N];

    // AXI slave: samples handshakes at negedge, reacts after the next posedge.
    initial begin
        logic        s_aw, s_w, s_b, s_ar, s_r;
        logic [31:0] s_addr, s_data, s_araddr, cur_addr, cur_data, rd;
        bit          got_aw, got_w;
        int          aw_cnt, w_cnt, b_cnt, idx;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        cur_addr = 0; cur_data = 0;
        forever begin
            @(negedge clk);
            s_aw = axi_awvalid && axi_awready; s_addr = axi_awaddr;
            s_w  = axi_wvalid && axi_wready;   s_data = axi_wdata;
            s_b  = axi_bvalid && axi_bready;
            s_ar = axi_arvalid && axi_arready; s_araddr = axi_araddr;
            s_r  = axi_rvalid && axi_rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
                axi_arready = 0; axi_rvalid = 0; axi_rdata = 0;
                got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (s_aw) begin got_aw = 1; cur_addr = s_addr; end
                if (s_w) begin got_w = 1; cur_data = s_data; end
                if (s_b) axi_bvalid = 0;
                if (got_aw && got_w) begin
                    if (b_cnt >= b_lat) begin
                        idx = int'((cur_addr - BASE) >> 2);
                        axi_bresp = (log_addr.size() == bad_tap) ? 2'b10 : 2'b00;
                        log_addr.push_back(cur_addr);
                        log_data.push_back(cur_data);
                        if (idx >= 0 && idx < N) mem[idx] = cur_data;
                        axi_bvalid = 1; got_aw = 0; got_w = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (s_aw || !axi_awvalid) aw_cnt = 0;
                axi_awready = axi_awvalid && !stuck_aw && (aw_cnt >= aw_lat);
                if (axi_awvalid) aw_cnt++;
                if (s_w || !axi_wvalid) w_cnt = 0;
                axi_wready = axi_wvalid && (w_cnt >= w_lat);
                if (axi_wvalid) w_cnt++;
                if (s_r) axi_rvalid = 0;
                if (s_ar) begin
                    idx = int'((s_araddr - BASE) >> 2);
                    rd = (idx >= 0 && idx < N) ? mem[idx] : 32'h0;
                    if (idx == bad_rd_tap)
                        rd = (rd[15:0] == 16'h2001) ? 32'h2002 : 32'h2001;
                    axi_rdata = rd; axi_rresp = 2'b00; axi_rvalid = 1;
                end
                axi_arready = axi_arvalid;
            end
        end
    end

    // Per-cycle compare against the load model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_load = 0;
                chk("reset_flags", {busy, done, err_code, err_index, axi_awvalid,
                    axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
                chk("reset_addr_data", {axi_awaddr, axi_wdata}, 0);
                chk("reset_araddr", axi_araddr, 0);
            end else begin
                chk("prot_strb", {axi_awprot, axi_arprot, axi_wstrb}, {3'b0, 3'b0, 4'hF});
                if (RB == 0)
                    chk("rd_tied", {axi_arvalid, axi_rready, axi_araddr}, 0);
                if (in_load) begin
                    if (axi_awvalid)
                        chk("awaddr", axi_awaddr, BASE + 32'(aw_n) * 4);
                    if (axi_wvalid)
                        chk("wdata", axi_wdata, {16'h0, exp_coeff[w_n % N]});
                    chk("busy", busy, !done);
                    if (axi_awvalid && !axi_wvalid && w_n > aw_n) saw_split = 1;
                    if (axi_awvalid && axi_awready) aw_n++;
                    if (axi_wvalid && axi_wready) w_n++;
                    if (done) begin
                        in_load = 0;
                        done_count++;
                        done_cycle = cyc;
                    end
                end else begin
                    chk("idle_quiet", {busy, done, axi_awvalid, axi_wvalid,
                        axi_bready, axi_arvalid, axi_rready}, 0);
                    if (start) begin
                        in_load = 1; aw_n = 0; w_n = 0; saw_split = 0;
                        start_cycle = cyc;
                        for (int k = 0; k < N; k++)
                            exp_coeff[k] = (preset == 2'd3) ? user_coeffs[16*k +: 16]
                                                            : tbl[preset][k];
                    end
                end
            end
            cyc++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic run_load(input logic [1:0] p, input logic [63:0] u,
                            input bit chk_clear, output bit ok);
        int d0;
        log_addr.delete();
        log_data.delete();
        d0 = done_count;
        @(posedge clk); #1;
        preset = p; user_coeffs = u; start = 1;
        @(posedge clk); #1;
        start = 0;
        preset = 2'($urandom);
        user_coeffs = {$urandom, $urandom};
        if (chk_clear) chk("err_cleared_on_start", err_code, 0);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #2;
            if (done_count != d0) begin ok = 1; break; end
        end
        chk("done_seen", 64'(ok), 1);
    endtask

    task automatic check_log(input int n_exp);
        chk("write_count", log_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < log_addr.size(); i++) begin
            chk("log_addr", log_addr[i], BASE + 32'(i) * 4);
            chk("log_data", log_data[i], {16'h0, exp_coeff[i]});
        end
    endtask

    initial begin
        bit          ok;
        int          lat, d0, exp_err, exp_idx, nw;
        logic [31:0] hp_addr [4];
        logic [15:0] hp_data [4];
        hp_addr = '{32'h0C, 32'h10, 32'h14, 32'h18};
        hp_data = '{16'h2000, 16'hE000, 16'hE000, 16'h2000};

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk); #2;
        chk("post_reset_err", {err_code, err_index}, 0);

        // Highpass, zero-wait slave, literal expectations.
        run_load(2'd1, 64'h0, 1'b1, ok);
        lat = done_cycle - start_cycle;
        chk("hp_latency", lat, 3 * N + 3 * N * RB + 1);
        chk("hp_err", err_code, 0);
        chk("hp_count", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("hp_addr_lit", log_addr[i], hp_addr[i]);
            chk("hp_data_lit", log_data[i], {16'h0, hp_data[i]});
        end

        // wready three cycles ahead of awready.
        aw_lat = 3; w_lat = 0;
        run_load(2'd0, 64'h0, 1'b0, ok);
        chk("split_seen", 64'(saw_split), 1);
        chk("aw_hs_count", aw_n, N);
        chk("w_hs_count", w_n, N);
        chk("split_err", err_code, 0);
        check_log(N);
        aw_lat = 0;

        // Bad write response on tap 2.
        bad_tap = 2;
        run_load(2'd2, 64'h0, 1'b0, ok);
        chk("bresp_err", {err_code, err_index}, {2'd1, 2'd2});
        check_log(3);
        bad_tap = -1;

        // Second start after an error clears err_code.
        run_load(2'd3, 64'h1234_5678_9ABC_DEF0, 1'b1, ok);
        chk("clean_after_err", {err_code, err_index}, 0);
        check_log(N);

        // awready stuck: watchdog ends the load.
        stuck_aw = 1;
        run_load(2'd0, 64'h0, 1'b0, ok);
        lat = done_cycle - start_cycle;
        chk("timeout_window", 64'(lat >= T && lat <= T + 4), 1);
        chk("timeout_err", {err_code, err_index}, {2'd3, 2'd0});
        chk("timeout_valids", {axi_awvalid, axi_wvalid, axi_bready}, 0);
        stuck_aw = 0;
        do_reset();

`ifdef FIR_COEFF_READBACK_EN
        // Readback corruption on tap 1.
        bad_rd_tap = 1;
        run_load(2'd1, 64'h0, 1'b0, ok);
        chk("rdbk_err", {err_code, err_index}, {2'd2, 2'd1});
        check_log(N);
        bad_rd_tap = -1;
`endif

        // Start while busy is ignored.
        log_addr.delete();
        log_data.delete();
        d0 = done_count;
        @(posedge clk); #1; preset = 2'd2; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (3) @(posedge clk);
        #1 preset = 2'd0; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (60) @(negedge clk);
        #2;
        chk("busy_start_one_done", done_count - d0, 1);
        chk("busy_start_count", log_addr.size(), N);
        if (log_data.size() > 0)
            chk("busy_start_tap0", log_data[0], 32'h7FFF);

        // Reset in the middle of a load.
        d0 = done_count;
        @(posedge clk); #1; preset = 2'd1; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort_flags", {busy, done, err_code, err_index, axi_awvalid,
            axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
        chk("abort_addr_data", {axi_awaddr, axi_wdata}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_count - d0, 0);

        // Randomized loads with random slave timing and faults.
        for (int it = 0; it < 24; it++) begin
            aw_lat = $urandom_range(0, 4);
            w_lat  = $urandom_range(0, 4);
            b_lat  = $urandom_range(0, 3);
            bad_tap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
            bad_rd_tap = (RB == 1 && $urandom_range(0, 3) == 0) ?
                         $urandom_range(0, N - 1) : -1;
            run_load(2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b1, ok);
            if (bad_tap >= 0) begin
                exp_err = 1; exp_idx = bad_tap; nw = bad_tap + 1;
            end else if (bad_rd_tap >= 0) begin
                exp_err = 2; exp_idx = bad_rd_tap; nw = N;
            end else begin
                exp_err = 0; exp_idx = 0; nw = N;
            end
            chk("rand_err", {err_code, err_index}, {2'(exp_err), 2'(exp_idx)});
            check_log(nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
